// File: rtl/aer_in_arbiter_pkg.sv
// Shared types and helpers for the AER_IN source arbiter.
// Imported by the picker and the arbiter top.
package aer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_LO
  } arb_state_t;

  localparam int AER_ADDR_W_DEF = 12;

  function automatic int rr_idx(
    input int last,
    input int k,
    input int n
  );
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/aer_in_arbiter_if.sv
// Source-side and core-side 4-phase AER handshake bundle.
// master = arbiter view, slave = sources/core view.
interface aer_in_arbiter_if #(
  parameter int N_SRC  = 2,
  parameter int ADDR_W = 12
);

  logic [N_SRC-1:0]        src_req;
  logic [N_SRC*ADDR_W-1:0] src_addr;
  logic [N_SRC-1:0]        src_ack;
  logic                    AER_IN_REQ;
  logic [ADDR_W-1:0]       AER_IN_ADDR;
  logic                    AER_IN_ACK;

  modport master (
    input  src_req,
    input  src_addr,
    input  AER_IN_ACK,
    output src_ack,
    output AER_IN_REQ,
    output AER_IN_ADDR
  );

  modport slave (
    output src_req,
    output src_addr,
    output AER_IN_ACK,
    input  src_ack,
    input  AER_IN_REQ,
    input  AER_IN_ADDR
  );

endinterface

// File: rtl/aer_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester
// found scanning upward from last_grant+1.
module aer_rr_pick
  import aer_arb_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IW-1:0]    last_grant_i,
  output logic             valid_o,
  output logic [IW-1:0]    index_o
);

  logic [IW-1:0] j;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    j       = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      j = IW'(rr_idx(int'(last_grant_i), k, N_SRC));
      if (req_i[j]) begin
        valid_o = 1'b1;
        index_o = j;
      end
    end
  end

endmodule

// File: rtl/aer_in_arbiter.sv
// Round-robin arbiter sharing the 4-phase AER_IN bus
// between N_SRC event sources, with optional ACK timeout.
module aer_in_arbiter
  import aer_arb_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int ADDR_W      = AER_ADDR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 0,
  parameter int EVCNT_W     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  aer_in_arbiter_if.master         bus,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr,
  output logic [EVCNT_W-1:0]       ev_cnt
);

  localparam int IW = $clog2(N_SRC);
  localparam int TW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;

  arb_state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [IW-1:0]          last_q, grant_q;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic [ADDR_W-1:0]      addr_q, pick_addr;
  logic [TW-1:0]          tmo_q;
  logic                   tmo_hit;
  logic                   err_q;
  logic [EVCNT_W-1:0]     cnt_q;
  logic                   gnt_req;

  aer_rr_pick #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_pick (
    .req_i        (bus.src_req),
    .last_grant_i (last_q),
    .valid_o      (pick_vld),
    .index_o      (pick_idx)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_addr = bus.src_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign gnt_req = bus.src_req[grant_q];
  // Fires on the cycle that would bring the wait count to TIMEOUT_CYC.
  assign tmo_hit = (TIMEOUT_CYC > 0) &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) state_d = REQ;
      end
      REQ: begin
        if (ack_s || tmo_hit) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!ack_s && !gnt_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.AER_IN_REQ  = (state_q == REQ);
    bus.AER_IN_ADDR = addr_q;
    bus.src_ack     = '0;
    if (state_q == WAIT_LO) bus.src_ack[grant_q] = 1'b1;
    busy            = (state_q != IDLE);
    grant_id        = grant_q;
    timeout_err     = err_q;
    ev_cnt          = cnt_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(N_SRC - 1);
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.AER_IN_ACK);
      if (state_q == IDLE && pick_vld) begin
        addr_q  <= pick_addr;
        grant_q <= pick_idx;
        last_q  <= pick_idx;
        tmo_q   <= '0;
      end else if (state_q == REQ && !tmo_hit) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (state_q == REQ && ack_s) begin
        cnt_q <= cnt_q + EVCNT_W'(1);
      end
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (state_q == REQ && !ack_s && tmo_hit) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aer_in_arbiter.sv
// Directed bench for aer_in_arbiter: behavioural sources
// and core, table-driven single events plus corner sequences.
module tb_aer_in_arbiter;

  typedef struct {
    int          src;
    logic [11:0] addr;
    int          dly;
    logic [11:0] exp_addr;
    int          exp_gid;
    int          exp_cnt;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        err_clr;
  logic [0:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [15:0] ev_cnt;

  aer_in_arbiter_if #(.N_SRC(2), .ADDR_W(12)) bus ();

  aer_in_arbiter #(
    .N_SRC       (2),
    .ADDR_W      (12),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (64),
    .EVCNT_W     (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .ev_cnt      (ev_cnt)
  );

  int n_chk;
  int n_pass;
  int viol;

  bit          auto_en;
  bit          core_en;
  int          core_dly;
  logic [1:0]  man_req;
  logic [11:0] man_addr [2];
  logic [1:0]  a_req;
  logic [11:0] a_addr [2];
  int          ph [2];
  int          done [2];
  int          total [2];
  logic [11:0] tab [2][1024];
  logic        core_ack;
  int          cwait;
  logic [11:0] seen_a [$];
  int          seen_g [$];
  logic        prev_req;
  logic [11:0] held;

  assign bus.src_req    = auto_en ? a_req : man_req;
  assign bus.src_addr   = auto_en ? {a_addr[1], a_addr[0]}
                                  : {man_addr[1], man_addr[0]};
  assign bus.AER_IN_ACK = core_ack;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Auto sources: one 4-phase handshake per tab entry.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        ph[i]    <= 0;
        a_req[i] <= 1'b0;
      end else begin
        case (ph[i])
          0: if (auto_en && done[i] < total[i]) begin
            a_req[i]  <= 1'b1;
            a_addr[i] <= tab[i][done[i]];
            ph[i]     <= 1;
          end
          1: if (bus.src_ack[i]) begin
            a_req[i] <= 1'b0;
            ph[i]    <= 2;
          end
          default: if (!bus.src_ack[i]) begin
            done[i] <= done[i] + 1;
            ph[i]   <= 0;
          end
        endcase
      end
    end
  end

  // Core: ACK after core_dly cycles, release once REQ drops.
  always @(negedge CLK) begin
    if (RST) begin
      core_ack <= 1'b0;
      cwait    <= 0;
    end else if (!core_ack) begin
      if (bus.AER_IN_REQ && core_en) begin
        if (cwait >= core_dly) begin
          core_ack <= 1'b1;
          cwait    <= 0;
        end else begin
          cwait <= cwait + 1;
        end
      end else begin
        cwait <= 0;
      end
    end else if (!bus.AER_IN_REQ) begin
      core_ack <= 1'b0;
    end
  end

  always @(negedge CLK) begin : mon
    int v;
    v = 0;
    prev_req <= bus.AER_IN_REQ;
    if (!RST) begin
      if (bus.AER_IN_REQ && !prev_req) begin
        seen_a.push_back(bus.AER_IN_ADDR);
        seen_g.push_back(int'(grant_id));
        held <= bus.AER_IN_ADDR;
        if (core_ack) v++;
      end else if ((bus.AER_IN_REQ || core_ack) &&
                   bus.AER_IN_ADDR != held) begin
        v++;
      end
      if (bus.src_ack != 2'b00 && bus.AER_IN_REQ) v++;
      if (bus.src_ack == 2'b11) v++;
    end
    viol <= viol + v;
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] qa(int k);
    if (k < seen_a.size()) return 32'(seen_a[k]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qg(int k);
    if (k < seen_g.size()) return 32'(seen_g[k]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic wait_ack(string nm, logic [1:0] m,
                          logic lvl, int budget);
    int k = 0;
    while ((((bus.src_ack & m) != 2'b00) != lvl) &&
           k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk(nm, 32'(((bus.src_ack & m) != 2'b00)), 32'(lvl));
  endtask

  task automatic wait_idle(string nm, int budget);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!(done[0] == total[0] && done[1] == total[1] &&
                 !busy) && k < budget);
    chk(nm, 32'(done[0] == total[0] && done[1] == total[1] &&
                !busy), 32'd1);
  endtask

  initial begin
    vec_t vt [5];
    int   base;
    int   k;
    int   mis;
    bit   ok;

    RST      = 1'b1;
    err_clr  = 1'b0;
    auto_en  = 1'b1;
    core_en  = 1'b1;
    core_dly = 0;
    man_req  = 2'b00;
    man_addr[0] = '0;
    man_addr[1] = '0;
    total[0] = 0;
    total[1] = 0;
    n_chk    = 0;
    n_pass   = 0;

    vt[0] = '{0, 12'h001, 10, 12'h001, 0, 1};
    vt[1] = '{0, 12'h002, 10, 12'h002, 0, 2};
    vt[2] = '{0, 12'h30F, 10, 12'h30F, 0, 3};
    vt[3] = '{0, 12'hFFF,  0, 12'hFFF, 0, 4};
    vt[4] = '{1, 12'h7AB,  3, 12'h7AB, 1, 5};

    repeat (3) @(negedge CLK);
    chk("rst_req", 32'(bus.AER_IN_REQ), 0);
    chk("rst_ack", 32'(bus.src_ack), 0);
    chk("rst_addr", 32'(bus.AER_IN_ADDR), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_cnt", 32'(ev_cnt), 0);
    RST = 1'b0;
    @(negedge CLK);

    foreach (vt[r]) begin
      core_dly = vt[r].dly;
      base     = seen_a.size();
      tab[vt[r].src][total[vt[r].src]] = vt[r].addr;
      total[vt[r].src]++;
      wait_idle($sformatf("t1_done%0d", r), 300);
      chk($sformatf("t1_nev%0d", r), 32'(seen_a.size() - base), 1);
      chk($sformatf("t1_addr%0d", r), qa(base), 32'(vt[r].exp_addr));
      chk($sformatf("t1_gid%0d", r), qg(base), 32'(vt[r].exp_gid));
      chk($sformatf("t1_cnt%0d", r), 32'(ev_cnt), 32'(vt[r].exp_cnt));
    end

    core_dly = 3;
    base     = seen_a.size();
    for (int i = 0; i < 3; i++) begin
      tab[0][total[0] + i] = 12'h005;
      tab[1][total[1] + i] = 12'h123;
    end
    total[0] += 3;
    total[1] += 3;
    wait_idle("t2_done", 600);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_addr%0d", i), qa(base + i),
          (i % 2) ? 32'h123 : 32'h005);
      chk($sformatf("t2_gid%0d", i), qg(base + i), 32'(i % 2));
    end
    chk("t2_cnt", 32'(ev_cnt), 11);

    core_en = 1'b0;
    base    = seen_a.size();
    tab[0][total[0]] = 12'h2AA;
    total[0]++;
    k = 0;
    while (!bus.AER_IN_REQ && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("t3_req_rise", 32'(bus.AER_IN_REQ), 1);
    k = 0;
    while (bus.AER_IN_REQ && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("t3_req_len", 32'(k), 64);
    chk("t3_err_set", 32'(timeout_err), 1);
    chk("t3_src_ack", 32'(bus.src_ack), 32'b01);
    wait_idle("t3_done", 50);
    chk("t3_addr", qa(base), 32'h2AA);
    chk("t3_cnt", 32'(ev_cnt), 11);
    repeat (5) @(negedge CLK);
    chk("t3_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(timeout_err), 0);
    core_en = 1'b1;

    auto_en  = 1'b0;
    core_dly = 2;
    base     = seen_a.size();
    @(negedge CLK);
    man_addr[0] = 12'h0AB;
    man_req     = 2'b01;
    wait_ack("t5_ack_hi", 2'b01, 1'b1, 40);
    k = 0;
    while (core_ack && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("t5_core_lo", 32'(core_ack), 0);
    ok = 1'b1;
    repeat (50) begin
      @(negedge CLK);
      if (!busy || bus.src_ack != 2'b01 || bus.AER_IN_REQ) ok = 1'b0;
    end
    chk("t5_hold", 32'(ok), 1);
    man_req = 2'b00;
    wait_ack("t5_ack_lo", 2'b01, 1'b0, 20);
    wait_idle("t5_done", 20);
    chk("t5_nev", 32'(seen_a.size() - base), 1);
    chk("t5_cnt", 32'(ev_cnt), 12);

    @(negedge CLK);
    man_addr[0] = 12'h111;
    man_req     = 2'b01;
    @(negedge CLK);
    chk("t4_latency", 32'(bus.AER_IN_REQ), 1);
    wait_ack("t4_ack_hi", 2'b01, 1'b1, 40);
    #2 RST = 1'b1;
    #1;
    chk("t4_rst_outs", 32'({bus.AER_IN_REQ, bus.src_ack,
        bus.AER_IN_ADDR, grant_id, busy, timeout_err}), 0);
    chk("t4_rst_cnt", 32'(ev_cnt), 0);
    @(negedge CLK);
    RST     = 1'b0;
    man_req = 2'b00;
    @(negedge CLK);
    man_addr[0] = 12'h0A0;
    man_addr[1] = 12'h0B1;
    man_req     = 2'b11;
    @(negedge CLK);
    chk("t4_req", 32'(bus.AER_IN_REQ), 1);
    chk("t4_gid", 32'(grant_id), 0);
    chk("t4_addr", 32'(bus.AER_IN_ADDR), 32'h0A0);
    wait_ack("t4_ack0", 2'b01, 1'b1, 40);
    man_req[0] = 1'b0;
    wait_ack("t4_ack1", 2'b10, 1'b1, 60);
    chk("t4_addr1", 32'(bus.AER_IN_ADDR), 32'h0B1);
    man_req[1] = 1'b0;
    wait_idle("t4_done", 40);
    chk("t4_cnt", 32'(ev_cnt), 2);
    auto_en = 1'b1;

    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("t6_cnt0", 32'(ev_cnt), 0);
    core_dly = 0;
    base     = seen_a.size();
    for (int i = 0; i < 784; i++) tab[0][total[0] + i] = 12'(i);
    total[0] += 784;
    wait_idle("t6_done", 30000);
    chk("t6_nev", 32'(seen_a.size() - base), 784);
    mis = 0;
    for (int i = 0; i < 784; i++) begin
      if (qa(base + i) != 32'(i)) mis++;
    end
    chk("t6_seq", 32'(mis), 0);
    chk("t6_cnt", 32'(ev_cnt), 784);

    chk("protocol", 32'(viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
